// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: run controller state encoding and default parameter values
package run_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;
  localparam int CW_DEF      = 16;
  localparam int MAX_CYC_DEF = 16'hFFFF;
  localparam int RST_CYC_DEF = 2;
endpackage

// File: rtl/dm_port_mux.sv
// dm_port_mux: grant=1 routes host_{wr_en,addr,dat} to mem_*, grant=0 routes core_*; the other source is dropped
module dm_port_mux (
  input  logic       grant,
  input  logic       host_wr_en,
  input  logic [7:0] host_addr,
  input  logic [7:0] host_dat,
  input  logic       core_wr_en,
  input  logic [7:0] core_addr,
  input  logic [7:0] core_dat,
  output logic       mem_wr_en,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_dat
);
  assign mem_wr_en = grant ? host_wr_en : core_wr_en;
  assign mem_addr  = grant ? host_addr  : core_addr;
  assign mem_dat   = grant ? host_dat   : core_dat;
endmodule

// File: rtl/run_ctrl.sv
// run_ctrl: per-request core run sequencer (req/done four-phase, halt or watchdog stop, cycle count) with host/core dat_mem write mux
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int CW      = CW_DEF,
  parameter int MAX_CYC = MAX_CYC_DEF,
  parameter int RST_CYC = RST_CYC_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          halt,
  output logic          core_reset,
  output logic          core_en,
  output logic          done,
  output logic          timeout,
  output logic [CW-1:0] cycles,
  output logic          host_grant,
  input  logic          host_wr_en,
  input  logic [7:0]    host_addr,
  input  logic [7:0]    host_dat,
  input  logic          core_wr_en,
  input  logic [7:0]    core_addr,
  input  logic [7:0]    core_dat,
  output logic          mem_wr_en,
  output logic [7:0]    mem_addr,
  output logic [7:0]    mem_dat
);
  localparam int RW = $clog2(RST_CYC + 1);
  state_t state, next;
  logic [RW-1:0] rst_cnt;
  logic [CW-1:0] cyc_inc;
  logic wd;
  assign cyc_inc = cycles + 1'b1;
  assign wd = cyc_inc == CW'(MAX_CYC);
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    core_reset = 1'b0;
    core_en = 1'b0;
    done = 1'b0;
    host_grant = 1'b0;
    case (state)
      IDLE: begin
        core_reset = 1'b1;
        host_grant = 1'b1;
        next = req ? CLEAR : IDLE;
      end
      CLEAR: begin
        core_reset = 1'b1;
        next = (rst_cnt == RW'(RST_CYC - 1)) ? RUN : CLEAR;
      end
      RUN: begin
        core_en = 1'b1;
        next = (halt || wd) ? DONE : RUN;
      end
      DONE: begin
        done = 1'b1;
        host_grant = 1'b1;
        next = req ? DONE : IDLE;
      end
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cycles <= '0;
      timeout <= 1'b0;
      rst_cnt <= '0;
    end else if (state == IDLE && req) begin
      cycles <= '0;
      timeout <= 1'b0;
      rst_cnt <= '0;
    end else if (state == CLEAR) begin
      rst_cnt <= rst_cnt + 1'b1;
    end else if (state == RUN) begin
      cycles <= cyc_inc;
      timeout <= !halt && wd;
    end
  dm_port_mux u_mux (
    .grant      (host_grant),
    .host_wr_en (host_wr_en),
    .host_addr  (host_addr),
    .host_dat   (host_dat),
    .core_wr_en (core_wr_en),
    .core_addr  (core_addr),
    .core_dat   (core_dat),
    .mem_wr_en  (mem_wr_en),
    .mem_addr   (mem_addr),
    .mem_dat    (mem_dat)
  );
endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: randomized scoreboard bench for run_ctrl with a counting core model raising halt on a chosen RUN cycle
module tb_run_ctrl;
  localparam int CW = 16, MAXC = 20, RSTC = 2;
  logic clk = 0, reset = 1, req = 0, halt;
  logic core_reset, core_en, done, timeout, host_grant, mem_wr_en;
  logic [CW-1:0] cycles;
  logic host_wr_en = 0, core_wr_en = 0;
  logic [7:0] host_addr = 0, host_dat = 0, core_addr = 0, core_dat = 0, mem_addr, mem_dat;
  int total = 0, bad = 0, halt_at = 0, run_cnt = 0, en_cnt = 0, clr_cnt = 0;
  bit prev_done = 0;
  typedef struct {int cyc; bit to;} exp_t;
  exp_t exp_q[$];
  always #5 clk = ~clk;
  run_ctrl #(.CW(CW), .MAX_CYC(MAXC), .RST_CYC(RSTC)) dut (
    .clk(clk), .reset(reset), .req(req), .halt(halt),
    .core_reset(core_reset), .core_en(core_en), .done(done), .timeout(timeout),
    .cycles(cycles), .host_grant(host_grant),
    .host_wr_en(host_wr_en), .host_addr(host_addr), .host_dat(host_dat),
    .core_wr_en(core_wr_en), .core_addr(core_addr), .core_dat(core_dat),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_dat(mem_dat)
  );
  assign halt = core_en && halt_at > 0 && run_cnt == halt_at - 1;
  always @(posedge clk) run_cnt <= core_reset ? 0 : (core_en ? run_cnt + 1 : run_cnt);
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (reset) begin
      en_cnt = 0;
      clr_cnt = 0;
      prev_done = 0;
    end else begin
      if (core_en) en_cnt++;
      if (core_reset && !host_grant) clr_cnt++;
      if (done && !prev_done) begin
        chk("done_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("cycles", cycles, e.cyc);
          chk("timeout", timeout, e.to);
          chk("en_cycles", en_cnt, e.cyc);
          chk("clear_cycles", clr_cnt, RSTC);
          chk("done_core_en", core_en, 0);
          chk("done_core_reset", core_reset, 0);
          chk("done_grant", host_grant, 1);
        end
        en_cnt = 0;
        clr_cnt = 0;
      end
      prev_done = done;
    end
  end
  task automatic do_run(input int h, input bit drop, input int hold, input bit mux);
    exp_t e;
    int n;
    halt_at = h;
    e.to = !(h > 0 && h <= MAXC);
    e.cyc = e.to ? MAXC : h;
    @(negedge clk);
    exp_q.push_back(e);
    req = 1;
    if (mux) begin
      n = 0;
      while (!core_en && n < 20) begin @(negedge clk); n++; end
      host_wr_en = 1; host_addr = 8'h77; host_dat = 8'h11;
      core_wr_en = 1; core_addr = 8'h03; core_dat = 8'h3C;
      #1;
      chk("run_mem_wr_en", mem_wr_en, 1);
      chk("run_mem_addr", mem_addr, 8'h03);
      chk("run_mem_dat", mem_dat, 8'h3C);
      core_wr_en = 0;
      #1;
      chk("run_host_dropped", mem_wr_en, 0);
      host_wr_en = 0;
    end
    if (drop) begin
      repeat (4) @(negedge clk);
      req = 0;
    end
    n = 0;
    while (!done && n < MAXC + RSTC + 10) begin @(negedge clk); n++; end
    chk("done_seen", done, 1);
    if (!drop) begin
      repeat (hold) begin
        @(negedge clk);
        chk("done_hold", done, 1);
      end
      req = 0;
    end
    @(negedge clk);
    chk("idle_done", done, 0);
    chk("idle_grant", host_grant, 1);
    chk("idle_core_reset", core_reset, 1);
    chk("idle_cycles", cycles, e.cyc);
    chk("idle_timeout", timeout, e.to);
  endtask
  initial begin
    #2;
    chk("rst_core_reset", core_reset, 1);
    chk("rst_core_en", core_en, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_cycles", cycles, 0);
    chk("rst_grant", host_grant, 1);
    @(negedge clk);
    reset = 0;
    host_wr_en = 1; host_addr = 8'h10; host_dat = 8'hA5;
    core_wr_en = 1; core_addr = 8'h55; core_dat = 8'h66;
    #1;
    chk("idle_mem_wr_en", mem_wr_en, 1);
    chk("idle_mem_addr", mem_addr, 8'h10);
    chk("idle_mem_dat", mem_dat, 8'hA5);
    host_wr_en = 0; core_wr_en = 0;
    do_run(5, 0, 10, 0);
    do_run(0, 0, 2, 1);
    do_run(MAXC, 0, 1, 0);
    do_run(12, 1, 0, 0);
    do_run(1, 0, 1, 0);
    halt_at = 0;
    @(negedge clk);
    req = 1;
    repeat (RSTC + 4) @(negedge clk);
    #2 reset = 1;
    #1;
    chk("abort_core_reset", core_reset, 1);
    chk("abort_core_en", core_en, 0);
    chk("abort_done", done, 0);
    chk("abort_cycles", cycles, 0);
    chk("abort_grant", host_grant, 1);
    @(negedge clk);
    #1 reset = 0;
    req = 0;
    do_run(7, 0, 1, 0);
    for (int i = 0; i < 14; i++) begin
      int h;
      bit d;
      h = $urandom_range(0, 25);
      d = (h == 0 || h >= 6) && ($urandom_range(0, 1) == 1);
      do_run(h, d, $urandom_range(0, 3), 0);
    end
    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "bench time limit");
  end
endmodule

// File: doc/run_ctrl.md
# run_ctrl

Run controller for the 9-bit-ISA core. Sequences one program execution per host request: holds the core in reset, releases it, and counts execute cycles. Stops on the halt instruction or a watchdog limit, then reports completion with a four-phase req/done handshake. Between runs it gives the host ownership of the data-memory write port, so operands can be preloaded without a separate loader path.

## Interface
Parameters:
- CW, 16, width of cycle counter
- MAX_CYC, 16'hFFFF, watchdog limit in RUN cycles (1..2^CW-1)
- RST_CYC, 2, cycles core_reset stays asserted in CLEAR (≥1)

Ports:
- clk  in  1  single clock; all state on posedge
- reset  in  1  asynchronous, active-high
- req  in  1  host start request (level, four-phase)
- halt  in  1  core at halt instruction (mach_code all ones), combinational from core
- core_reset  out  1  reset to core PC/regs/flags
- core_en  out  1  core advance enable
- done  out  1  run finished
- timeout  out  1  run ended by watchdog, valid while done=1
- cycles  out  CW  RUN cycles of last/current run
- host_grant  out  1  host owns data-memory port
- host_wr_en, host_addr[7:0], host_dat[7:0]  in  host memory write port
- core_wr_en, core_addr[7:0], core_dat[7:0]  in  core memory write port
- mem_wr_en, mem_addr[7:0], mem_dat[7:0]  out  to dat_mem

## Operation
- States IDLE, CLEAR, RUN, DONE. Single registered state; all status outputs are decoded from the state or from registers.
- IDLE: core_reset=1, core_en=0, done=0, host_grant=1.
  - req=1 → CLEAR; cycles←0, timeout←0, rst counter←0.
- CLEAR: core_reset=1, core_en=0, host_grant=0.
  - Stays exactly RST_CYC cycles, then → RUN.
- RUN: core_reset=0, core_en=1, host_grant=0.
  - Each cycle: cycles←cycles+1.
  - halt=1 → DONE, timeout←0; the halt cycle is counted.
  - halt=0 and cycles+1==MAX_CYC → DONE, timeout←1.
  - halt and watchdog in the same cycle: halt wins, timeout=0.
- DONE: done=1, core_en=0, core_reset=0, so core state stays inspectable; host_grant=1.
  - req=0 → IDLE. req still 1 → stay in DONE. No auto-restart.
- req deassertion during CLEAR/RUN is ignored; the run completes.
- cycles and timeout hold their values through DONE and IDLE until the next start.
- Memory mux, combinational:
  - host_grant=1 → mem_* = host_*.
  - host_grant=0 → mem_* = core_*.
  - Non-granted writes are dropped silently.
- cycles never wraps: MAX_CYC < 2^CW guarantees a watchdog stop first.

## Timing
- Reset (async, immediate): state=IDLE, core_reset=1, core_en=0, done=0, timeout=0, cycles=0, host_grant=1, rst counter=0.
- Reset mid-run aborts at once with no completion report.
- Cycle n: req sampled 1 in IDLE. Cycles n+1..n+RST_CYC: CLEAR. First RUN cycle: n+RST_CYC+1.
- Halt seen in the k-th RUN cycle: done=1 from the next cycle, cycles=k.
- Watchdog: exactly MAX_CYC RUN cycles, then done=1 with cycles=MAX_CYC.
- DONE→IDLE takes one cycle after req sampled 0. done falls in the same cycle IDLE is entered.
- Memory mux has zero latency. Grant switches on the state edge; no cycle carries a mixed source.

## Structure
- Package run_ctrl_pkg:
  - state_t enum {IDLE, CLEAR, RUN, DONE}, 2 bits.
  - Default constants CW_DEF, MAX_CYC_DEF, RST_CYC_DEF.
- One sub-module: dm_port_mux, the grant-driven 2:1 mux of {wr_en, addr, dat}.
- FSM, rst counter and cycle counter live in run_ctrl.

## Test plan
All scenarios use RST_CYC=2, MAX_CYC=20.
- **Halt run:** req rises at cycle 0, halt raised on the 5th RUN cycle → core_reset high cycles 0–2, core_en high for 5 cycles, done=1, cycles=5, timeout=0.
- **Watchdog:** halt never asserted → done after exactly 20 RUN cycles, cycles=20, timeout=1, core_en=0 in DONE.
- **Halt vs. watchdog:** halt on 20th RUN cycle → cycles=20, timeout=0.
- **Memory mux:**
  - IDLE, host writes addr 8'h10 data 8'hA5 → mem_wr_en=1, mem_addr=8'h10, mem_dat=8'hA5.
  - RUN, host write plus core write to addr 8'h03 data 8'h3C → mem shows core values only.
- **Handshake:**
  - req dropped mid-RUN → run still completes.
  - req held 1 in DONE for 10 cycles → done stays 1.
  - req→0 → IDLE next cycle, done=0, cycles retained.
- **Async reset:** reset pulsed mid-RUN between clock edges → outputs reach reset values before the next edge. Next req → full CLEAR sequence, cycles restarts from 0.
